// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped branch target buffer with per-entry
// saturating direction counters. It is looked up combinationally in IF with the
// current PC and updated from EX/MEM when a branch or jump resolves. It also
// keeps saturating lookup and mispredict statistics for the CPU tracker.
module branch_target_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              lookup_en,
  input  logic [WORD_W-1:0] lookup_pc,
  output logic              btb_hit,
  output logic              predict_taken,
  output logic [WORD_W-1:0] predict_next_pc,
  input  logic              upd_en,
  input  logic [WORD_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [WORD_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [WORD_W-1:0] upd_pred_target,
  input  logic              flush_all,
  output logic              mispredict,
  output logic [31:0]       lookup_count,
  output logic [31:0]       mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  // Counter values: saturation limit, allocation value (weakly taken) and
  // reset value (weakly not-taken, one below the taken threshold).
  localparam logic [CTR_W-1:0]  CTR_MAX     = '1;
  localparam logic [CTR_W-1:0]  CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0]  CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);
  localparam logic [WORD_W-1:0] PC_STEP     = WORD_W'(4);
  localparam logic [31:0]       STAT_MAX    = '1;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [WORD_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;

  // Word-aligned PCs: the two low bits never take part in index or tag.
  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[WORD_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[WORD_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Zero-latency lookup from registered state only; same-cycle updates are not bypassed.
  always_comb begin
    btb_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    predict_taken   = btb_hit && ctr_q[lk_idx][CTR_W-1];
    predict_next_pc = lookup_pc + PC_STEP;
    if (predict_taken) begin
      predict_next_pc = target_q[lk_idx];
    end
  end

  // Compare the resolved outcome against the prediction carried down the pipe.
  always_comb begin
    mispredict = 1'b0;
    if (upd_en) begin
      if (upd_taken != upd_pred_taken) begin
        mispredict = 1'b1;
      end else if (upd_taken && (upd_target != upd_pred_target)) begin
        mispredict = 1'b1;
      end else if (!upd_taken && (upd_pred_target != upd_pc + PC_STEP)) begin
        mispredict = 1'b1;
      end
    end
  end

  // Entry storage: reset beats flush, flush beats update, not-taken misses never allocate.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WEAK_NT;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (upd_en) begin
      if (up_hit) begin
        if (upd_taken) begin
          target_q[up_idx] <= upd_target;
          if (ctr_q[up_idx] != CTR_MAX) begin
            ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
          end
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
        end
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= CTR_WEAK_T;
      end
    end
  end

  // Statistics counters saturate instead of wrapping; flush does not touch them.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      lookup_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (lookup_en && (lookup_count != STAT_MAX)) begin
        lookup_count <= lookup_count + 32'd1;
      end
      if (mispredict && (mispredict_count != STAT_MAX)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: scoreboard bench. The driver issues one lookup and
// one update per cycle, pushes the expected outputs from a table-level model of
// the BTB into a queue, and a monitor on the falling edge pops and compares.
module tb_branch_target_predictor;

  localparam int ENTRIES = 16;
  localparam int CTR_W   = 2;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int CTR_MAXV = (1 << CTR_W) - 1;
  localparam int CTR_THR  = 1 << (CTR_W - 1);

  logic        CLK;
  logic        nRST;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        btb_hit;
  logic        predict_taken;
  logic [31:0] predict_next_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        flush_all;
  logic        mispredict;
  logic [31:0] lookup_count;
  logic [31:0] mispredict_count;

  branch_target_predictor #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .WORD_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .btb_hit(btb_hit), .predict_taken(predict_taken), .predict_next_pc(predict_next_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush_all(flush_all), .mispredict(mispredict),
    .lookup_count(lookup_count), .mispredict_count(mispredict_count)
  );

  // 10 time-unit clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        hit;
    logic        ptaken;
    logic [31:0] npc;
    logic        mis;
    logic [31:0] lcount;
    logic [31:0] mcount;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle_no = 0;

  // Reference model: a table keyed by word index holding the owning upper PC bits
  bit          m_valid  [ENTRIES];
  logic [31:0] m_owner  [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_lcount;
  logic [31:0] m_mcount;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] owner_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[slot_of(pc)] && (m_owner[slot_of(pc)] == owner_of(pc));
  endfunction

  function automatic bit model_taken(input logic [31:0] pc);
    return model_hit(pc) && (m_ctr[slot_of(pc)] >= CTR_THR);
  endfunction

  function automatic logic [31:0] model_npc(input logic [31:0] pc);
    return model_taken(pc) ? m_target[slot_of(pc)] : pc + 32'd4;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i]  = 1'b0;
      m_owner[i]  = 32'd0;
      m_target[i] = 32'd0;
      m_ctr[i]    = CTR_THR - 1;
    end
    m_lcount = 32'd0;
    m_mcount = 32'd0;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected, input int cyc);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d actual=%h expected=%h", name, cyc, actual, expected);
    end
  endtask

  // One cycle of stimulus: drive after the edge, record expectations, then advance the model.
  task automatic apply_stimulus(input logic rst_n, input logic l_en, input logic [31:0] l_pc,
                                input logic u_en, input logic [31:0] u_pc, input logic u_tk,
                                input logic [31:0] u_tgt, input logic p_tk,
                                input logic [31:0] p_tgt, input logic flush);
    exp_t e;
    bit   mis;
    int   s;
    @(posedge CLK);
    #1;
    cycle_no++;
    nRST = rst_n; lookup_en = l_en; lookup_pc = l_pc;
    upd_en = u_en; upd_pc = u_pc; upd_taken = u_tk; upd_target = u_tgt;
    upd_pred_taken = p_tk; upd_pred_target = p_tgt; flush_all = flush;
    mis = u_en && ((u_tk != p_tk) || (u_tk && u_tgt != p_tgt) ||
                   (!u_tk && p_tgt != u_pc + 32'd4));
    e.hit = model_hit(l_pc);
    e.ptaken = model_taken(l_pc);
    e.npc = model_npc(l_pc);
    e.mis = mis;
    e.lcount = m_lcount;
    e.mcount = m_mcount;
    e.cyc = cycle_no;
    exp_q.push_back(e);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (l_en && m_lcount != 32'hFFFF_FFFF) m_lcount = m_lcount + 32'd1;
      if (mis && m_mcount != 32'hFFFF_FFFF) m_mcount = m_mcount + 32'd1;
      if (flush) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
      end else if (u_en) begin
        s = slot_of(u_pc);
        if (model_hit(u_pc)) begin
          if (u_tk) begin
            m_target[s] = u_tgt;
            m_ctr[s] = (m_ctr[s] < CTR_MAXV) ? m_ctr[s] + 1 : CTR_MAXV;
          end else begin
            m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
          end
        end else if (u_tk) begin
          m_valid[s]  = 1'b1;
          m_owner[s]  = owner_of(u_pc);
          m_target[s] = u_tgt;
          m_ctr[s]    = CTR_THR;
        end
      end
    end
  endtask

  // Lookup-only cycle
  task automatic look(input logic [31:0] pc);
    apply_stimulus(1'b1, 1'b1, pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // Update with a lookup of the same PC in the same cycle
  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic p_tk, input logic [31:0] p_tgt);
    apply_stimulus(1'b1, 1'b1, pc, 1'b1, pc, tk, tgt, p_tk, p_tgt, 1'b0);
  endtask

  // Monitor: compare every presented output against the oldest expectation
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_output("btb_hit", {31'd0, btb_hit}, {31'd0, e.hit}, e.cyc);
      check_output("predict_taken", {31'd0, predict_taken}, {31'd0, e.ptaken}, e.cyc);
      check_output("predict_next_pc", predict_next_pc, e.npc, e.cyc);
      check_output("mispredict", {31'd0, mispredict}, {31'd0, e.mis}, e.cyc);
      check_output("lookup_count", lookup_count, e.lcount, e.cyc);
      check_output("mispredict_count", mispredict_count, e.mcount, e.cyc);
    end
  end

  // Directed scenarios first, then randomized traffic, then drain and summarize
  initial begin
    logic [31:0] pc, tgt, ptgt;
    logic        tk, ptk;
    int          waited;
    nRST = 1'b0; lookup_en = 1'b0; lookup_pc = 32'd0; upd_en = 1'b0; upd_pc = 32'd0;
    upd_taken = 1'b0; upd_target = 32'd0; upd_pred_taken = 1'b0; upd_pred_target = 32'd0;
    flush_all = 1'b0;
    repeat (2) @(posedge CLK);
    model_reset();

    look(32'h0000_0040);
    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    look(32'h40);
    upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h44);
    look(32'h40);
    repeat (4) upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    look(32'h40);
    upd(32'h80, 1'b1, 32'h200, 1'b0, 32'h84);
    look(32'h40);
    look(32'h80);
    look(32'hFFFF_FFFC);
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44, 1'b1);
    look(32'h40);
    look(32'h80);
    apply_stimulus(1'b1, 1'b0, 32'h40, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);

    @(negedge CLK);
    #1;
    force dut.mispredict_count = 32'hFFFF_FFFE;
    #1;
    release dut.mispredict_count;
    m_mcount = 32'hFFFF_FFFE;
    repeat (3) upd(32'h140, 1'b0, 32'h0, 1'b1, 32'h500);
    look(32'h140);

    upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h44);
    look(32'h40);
    apply_stimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h900, 1'b0, 32'h44, 1'b1);
    look(32'h40);

    for (int n = 0; n < 600; n++) begin
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 127)) << 2);
      tk  = 1'($urandom_range(0, 1));
      tgt = 32'($urandom_range(0, 15)) << 4;
      if ($urandom_range(0, 1) == 1) begin
        ptk  = model_taken(pc);
        ptgt = model_npc(pc);
      end else begin
        ptk  = 1'($urandom_range(0, 1));
        ptgt = ($urandom_range(0, 1) == 1) ? pc + 32'd4 : (32'($urandom_range(0, 15)) << 4);
      end
      apply_stimulus(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 1) == 1) ? pc : (32'($urandom_range(0, 127)) << 2),
                     1'($urandom_range(0, 3) != 0), pc, tk, tgt, ptk, ptgt,
                     ($urandom_range(0, 49) == 0));
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge CLK);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain actual=%0d expected=0 pending expectations", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
Name: branch_target_predictor

Overview:
- Parametrised branch target buffer (BTB) with per-entry saturating direction counters for the pipelined MIPS datapath.
- Looked up in IF with the current PC. Supplies a predicted next PC so taken branches and jumps no longer flush IF/ID.
- Updated from EX/MEM once a branch or jump resolves.
- Also keeps lookup and mispredict statistics for the CPU tracker.

Parameters:
- ENTRIES, 16, number of direct-mapped entries; power of two, 2 to 256.
- CTR_W, 2, width of each direction counter; 1 to 4.
- WORD_W, 32, address and data width.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
- lookup_en  input  1  IF stage has a valid PC this cycle; gates the statistics only.
- lookup_pc  input  WORD_W  current imemaddr.
- btb_hit  output  1  valid entry with matching tag.
- predict_taken  output  1  btb_hit AND counter MSB set.
- predict_next_pc  output  WORD_W  stored target if predict_taken, else lookup_pc+4.
- upd_en  input  1  resolved control-flow instruction in EX/MEM.
- upd_pc  input  WORD_W  PC of the resolved instruction.
- upd_taken  input  1  actual outcome.
- upd_target  input  WORD_W  actual target address.
- upd_pred_taken  input  1  prediction that was carried down the pipe.
- upd_pred_target  input  WORD_W  predicted next PC that was carried down the pipe.
- flush_all  input  1  invalidate every entry.
- mispredict  output  1  combinational; current update disagrees with its prediction.
- lookup_count  output  32  number of lookups.
- mispredict_count  output  32  number of mispredicts.

Behaviour:
- Address split, with IDX_W = log2(ENTRIES):
  - index = pc[IDX_W+1:2]
  - tag = pc[WORD_W-1:IDX_W+2]
  - pc[1:0] is ignored.
- Entry contents: valid (1 bit), tag, target (WORD_W), ctr (CTR_W).
- Lookup is purely combinational from registered state; zero-cycle latency.
- No write-to-read bypass: an update to the entry being looked up in the same cycle becomes visible on the next cycle.
- mispredict is asserted when upd_en=1 and any of these holds:
  - upd_taken != upd_pred_taken
  - upd_taken=1 and upd_target != upd_pred_target
  - upd_taken=0 and upd_pred_target != upd_pc+4
- Update on a rising edge with upd_en=1 and flush_all=0:
  - Hit (valid and tag match):
    - upd_taken=1: ctr increments, saturating at 2^CTR_W-1, and target is written with upd_target.
    - upd_taken=0: ctr decrements, saturating at 0, and target is held.
  - Miss, upd_taken=1: allocate the entry (overwriting any previous occupant). valid=1, tag written, target=upd_target, ctr=2^(CTR_W-1) (weakly taken).
  - Miss, upd_taken=0: no change; not-taken branches are never allocated.
- flush_all=1: every valid bit clears on the next edge. Flush wins over a simultaneous upd_en; that update is dropped. The statistics counters are unaffected.
- lookup_count increments on every edge where lookup_en=1.
- mispredict_count increments on every edge where mispredict=1, including cycles where flush_all=1.
- Both statistics counters saturate at 32'hFFFF_FFFF and never wrap.
- Reset (nRST low at an edge), including in the middle of operation:
  - all valid=0, all ctr=2^(CTR_W-1)-1 (weakly not-taken), all targets=0
  - lookup_count=0, mispredict_count=0
  - After the reset edge, btb_hit=0, predict_taken=0 and predict_next_pc=lookup_pc+4 until the first allocation.
- Reset overrides flush_all and upd_en.
- lookup_pc+4 and upd_pc+4 are computed modulo 2^WORD_W; 32'hFFFF_FFFC+4 gives 0.
- No handshake back-pressure: the block accepts one lookup and one update every cycle; the hazard unit decides when upd_en is valid.

Test Plan:
- Reset, then lookup_pc=32'h0000_0040 -> btb_hit=0, predict_taken=0, predict_next_pc=32'h0000_0044, both counters 0.
- Update upd_pc=32'h40, taken, target 32'h100, pred_taken=0, pred_target=32'h44 -> mispredict=1 and mispredict_count=1. Next cycle, lookup 32'h40 -> hit, predict_taken=1, predict_next_pc=32'h100.
- Two not-taken updates on 32'h40 (ctr 2->1->0) -> predict_taken=0, predict_next_pc=32'h44. Three taken updates -> ctr saturates at 3, with no wrap after a fourth.
- Alias, ENTRIES=16: allocate 32'h40 then taken update 32'h80 (same index, different tag) -> lookup 32'h40 misses, lookup 32'h80 hits with the new target.
- Same-cycle lookup and update of 32'h40 -> outputs reflect the old state; new state appears one cycle later. flush_all together with upd_en -> every lookup misses afterwards and the update is discarded.
- Preload mispredict_count=32'hFFFF_FFFE via forced mispredicts or a force in the bench; three further mispredicts -> counter holds at 32'hFFFF_FFFF. nRST low mid-stream -> all state is back to its reset values on the next edge.
